nn_wb_master: RTL and testbench

- Wishbone classic initiator that drives the NN accelerator's Wishbone slave port.
- Lets an on-chip sequencer or test controller load operands and read results without the management core.
- Accepts single-word read/write commands through a valid/ready queue and issues one Wishbone cycle per command.
- Returns one response per command (read data or write completion) in command order.

---
 rtl/nn_wbm_pkg.sv | 21 ++
 rtl/nn_wbm_cmd_fifo.sv | 59 +++++
 rtl/nn_wb_master.sv | 172 +++++++++++++++++
 tb/tb_nn_wb_master.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_wbm_pkg.sv
// Shared types for the NN accelerator Wishbone initiator: the queued command
// record, the bus FSM state encoding and the Wishbone bus widths.
package nn_wbm_pkg;

    localparam int WB_DW = 32;
    localparam int WB_AW = 32;

    typedef struct packed {
        logic             we;
        logic [3:0]       sel;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/nn_wbm_cmd_fifo.sv
// Synchronous command FIFO for the Wishbone initiator.
// Pointers carry one extra wrap bit so full and empty are told apart by
// comparing the MSBs; the head entry is presented combinationally on pop_data.
// Reset only flushes the pointers; stale storage is never visible while empty.
module nn_wbm_cmd_fifo
    import nn_wbm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    cmd_t        mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; natural wrap of the extended pointers, flushed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; no reset needed because empty masks old contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/nn_wb_master.sv
// Wishbone classic initiator driving the NN accelerator slave port.
// Single-word commands are queued in a small FIFO, each becomes one Wishbone
// cycle, and exactly one response per command is returned in command order.
// Optional build macro NN_WBM_TIMEOUT_EN adds an ack timeout that aborts a
// stalled cycle after TIMEOUT_CYC bus cycles and flags it on rsp_err_o.
module nn_wb_master
    import nn_wbm_pkg::*;
#(
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,

    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [3:0]       cmd_sel_i,
    input  logic [WB_AW-1:0] cmd_adr_i,
    input  logic [WB_DW-1:0] cmd_dat_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WB_DW-1:0] rsp_dat_o,
    output logic             rsp_err_o,

    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [WB_AW-1:0] wbm_adr_o,
    output logic [WB_DW-1:0] wbm_dat_o,
    input  logic [WB_DW-1:0] wbm_dat_i,
    input  logic             wbm_ack_i,

    output logic             busy_o
);

    state_t state;
    state_t state_next;

    cmd_t   cmd_in;
    cmd_t   cmd_head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_push;
    logic   fifo_pop;

    logic   bus_done;
    logic   timeout_hit;

    assign cmd_in      = '{we: cmd_we_i, sel: cmd_sel_i, adr: cmd_adr_i, dat: cmd_dat_i};
    assign cmd_ready_o = !fifo_full;
    assign fifo_push   = cmd_valid_i && !fifo_full;

    assign rsp_valid_o = (state == RESP);
    assign busy_o      = (state != IDLE) || !fifo_empty;

    nn_wbm_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (fifo_push),
        .push_data (cmd_in),
        .pop       (fifo_pop),
        .pop_data  (cmd_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef NN_WBM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] to_cnt;
    logic          rsp_err_q;

    assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign rsp_err_o   = rsp_err_q;

    // Counts cycles spent in BUS; restarts whenever a new cycle is launched.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            to_cnt <= '0;
        end else if (fifo_pop) begin
            to_cnt <= '0;
        end else if (state == BUS) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Error flag: set only when the cycle ended without an ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rsp_err_q <= 1'b0;
        end else if (bus_done) begin
            rsp_err_q <= !wbm_ack_i;
        end
    end
`else
    // Constant-false abort path; the parameter is referenced so both builds
    // share one parameter list without an unused-parameter warning.
    assign timeout_hit = 1'b0 & (TIMEOUT_CYC != 0);
    assign rsp_err_o   = 1'b0;
`endif

    // State register for the IDLE -> BUS -> RESP command loop.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: launch on a queued command, finish on ack (ack wins
    // over a same-cycle timeout), and hold the bus idle until the response
    // has been consumed so cycles are always separated by a strobe-low gap.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        bus_done   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i || timeout_hit) begin
                    bus_done   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus and response datapath: register the popped command onto the bus,
    // then capture read data (zero for writes or aborts) when the cycle ends.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_dat_o <= '0;
        end else if (fifo_pop) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_head.we;
            wbm_sel_o <= cmd_head.sel;
            wbm_adr_o <= cmd_head.adr;
            wbm_dat_o <= cmd_head.we ? cmd_head.dat : '0;
        end else if (bus_done) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat_o <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : '0;
        end
    end

endmodule

// File: tb/tb_nn_wb_master.sv
// Self-checking bench for nn_wb_master with a memory-model Wishbone slave.
// Expected responses come from a reference memory updated in command order at
// push time; bus-side expectations come from the same pushed command stream.
// Timeout scenario is exercised only when NN_WBM_TIMEOUT_EN is defined.
module tb_nn_wb_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [3:0]  cmd_sel_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic        rsp_valid_o;
    wire         rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        busy_o;

    int check_count = 0;
    int error_count = 0;

    // Reference model state
    typedef struct {
        logic [31:0] dat;
        logic        err;
    } rsp_s;
    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_s;

    logic [31:0] ref_mem [16];
    rsp_s        exp_rsp [$];
    bus_s        exp_bus [$];

    // Slave model controls
    logic [31:0] slave_mem [16];
    int          wait_cnt = 0;
    int          rand_waits = 0;
    int          cfg_waits = 0;
    bit          rand_mode = 1'b0;
    bit          ack_disable = 1'b0;
    bit          rand_rsp = 1'b0;
    logic        rsp_rdy_dir = 1'b0;
    logic        rsp_rdy_rand = 1'b0;

    // Monitor state
    bit          prev_ack = 1'b0;
    bit          prev_stb = 1'b0;
    logic [31:0] prev_adr = '0;
    int          stb_len = 0;
    int          last_stb_len = 0;

    assign rsp_ready_i = rand_rsp ? rsp_rdy_rand : rsp_rdy_dir;

    always #5 wb_clk_i = ~wb_clk_i;

    nn_wb_master #(
        .CMD_DEPTH   (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_sel_i   (cmd_sel_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .busy_o      (busy_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Slave acks combinationally once the configured number of wait states passed
    always_comb begin
        wbm_ack_i = wbm_cyc_o && wbm_stb_o && !ack_disable &&
                    (wait_cnt == (rand_mode ? rand_waits : cfg_waits));
        wbm_dat_i = slave_mem[wbm_adr_o[5:2]];
    end

    // Slave storage, wait-state counter and random wait selection
    always @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < 16; i++) slave_mem[i] <= ref_mem[i];
            wait_cnt <= 0;
        end else begin
            if (wbm_ack_i && wbm_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbm_sel_o[b]) slave_mem[wbm_adr_o[5:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
                end
            end
            if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) wait_cnt <= wait_cnt + 1;
            else wait_cnt <= 0;
            if (wbm_ack_i) rand_waits <= $urandom_range(0, 2);
        end
    end

    // Random response backpressure, changed just after each edge
    always @(posedge wb_clk_i) begin
        #2;
        rsp_rdy_rand = 1'($urandom_range(0, 1));
    end

    // Bus and response monitor, sampling on the falling edge
    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            prev_ack = 1'b0;
            prev_stb = 1'b0;
            stb_len  = 0;
        end else begin
            if (prev_ack) checkOutput("stb_gap", 32'(wbm_stb_o), 32'd0);
            else if (prev_stb && wbm_stb_o) checkOutput("adr_stable", wbm_adr_o, prev_adr);
            if (wbm_stb_o) stb_len++;
            else stb_len = 0;
            if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
                last_stb_len = stb_len;
                checkOutput("bus_expected", 32'(exp_bus.size() > 0), 32'd1);
                if (exp_bus.size() > 0) begin
                    bus_s b;
                    b = exp_bus.pop_front();
                    checkOutput("bus_we", 32'(wbm_we_o), 32'(b.we));
                    checkOutput("bus_adr", wbm_adr_o, b.adr);
                    checkOutput("bus_sel", 32'(wbm_sel_o), 32'(b.sel));
                    checkOutput("bus_dat", wbm_dat_o, b.dat);
                end
            end
            if (rsp_valid_o && rsp_ready_i) begin
                checkOutput("rsp_expected", 32'(exp_rsp.size() > 0), 32'd1);
                if (exp_rsp.size() > 0) begin
                    rsp_s r;
                    r = exp_rsp.pop_front();
                    checkOutput("rsp_dat", rsp_dat_o, r.dat);
                    checkOutput("rsp_err", 32'(rsp_err_o), 32'(r.err));
                end
            end
            prev_ack = wbm_cyc_o && wbm_stb_o && wbm_ack_i;
            prev_stb = wbm_stb_o;
            prev_adr = wbm_adr_o;
        end
    end

    // Record an accepted command in the reference model
    task automatic recordCmd(input logic we, input logic [3:0] sel,
                             input logic [31:0] adr, input logic [31:0] dat,
                             input bit exp_err);
        int idx;
        idx = int'(adr[5:2]);
        if (exp_err) begin
            exp_rsp.push_back('{dat: 32'd0, err: 1'b1});
        end else begin
            exp_bus.push_back('{we: we, sel: sel, adr: adr, dat: we ? dat : 32'd0});
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
                end
                exp_rsp.push_back('{dat: 32'd0, err: 1'b0});
            end else begin
                exp_rsp.push_back('{dat: ref_mem[idx], err: 1'b0});
            end
        end
    endtask

    // Offer one command; returns 2 time units after the accepting edge
    task automatic applyStimulus(input logic we, input logic [3:0] sel,
                                 input logic [31:0] adr, input logic [31:0] dat,
                                 input bit exp_err);
        bit accepted;
        accepted    = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_sel_i   = sel;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        for (int i = 0; i < 300; i++) begin
            @(negedge wb_clk_i);
            if (cmd_ready_o) begin
                accepted = 1'b1;
                break;
            end
        end
        checkOutput("push_accept", 32'(accepted), 32'd1);
        if (accepted) recordCmd(we, sel, adr, dat, exp_err);
        @(posedge wb_clk_i);
        #2;
        cmd_valid_i = 1'b0;
    endtask

    // Wait until every expected response has drained and the master is idle
    task automatic waitIdle(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge wb_clk_i);
            if (exp_rsp.size() == 0 && !busy_o && !rsp_valid_o) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(done), 32'd1);
        @(posedge wb_clk_i);
        #2;
    endtask

    function automatic logic [31:0] randAdr();
        return 32'h3000_0000 | (32'($urandom_range(0, 15)) << 2);
    endfunction

    initial begin
        bus_s bp_cmds [6];
        int   acc;
        int   cyc_cnt;
        int   seen;

        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_sel_i   = '0;
        cmd_adr_i   = '0;
        cmd_dat_i   = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        ref_mem[0] = 32'd0;
        ref_mem[1] = 32'd0;
        ref_mem[6] = 32'h3F00_0000;

        // Reset values
        wb_rst_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1;
        checkOutput("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("rst_rsp_dat", rsp_dat_o, 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        checkOutput("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        checkOutput("rst_stb", 32'(wbm_stb_o), 32'd0);
        checkOutput("rst_adr", wbm_adr_o, 32'd0);
        #1;
        wb_rst_i = 1'b0;

        // Write with zero-wait slave: cycle after edge k+1, response after k+2
        $display("[TB] write latency");
        applyStimulus(1'b1, 4'hF, 32'h3000_0000, 32'h3F80_0000, 1'b0);
        @(posedge wb_clk_i); #1;
        checkOutput("wr_cyc", 32'(wbm_cyc_o), 32'd1);
        checkOutput("wr_stb", 32'(wbm_stb_o), 32'd1);
        checkOutput("wr_we", 32'(wbm_we_o), 32'd1);
        checkOutput("wr_rsp_early", 32'(rsp_valid_o), 32'd0);
        @(posedge wb_clk_i); #1;
        checkOutput("wr_rsp_valid", 32'(rsp_valid_o), 32'd1);
        checkOutput("wr_rsp_dat", rsp_dat_o, 32'd0);
        checkOutput("wr_cyc_drop", 32'(wbm_cyc_o), 32'd0);
        #1;
        rsp_rdy_dir = 1'b1;
        waitIdle("wr_drain");

        // Read with three slave wait states
        $display("[TB] read with waits");
        cfg_waits = 3;
        applyStimulus(1'b0, 4'hF, 32'h3000_0018, 32'd0, 1'b0);
        waitIdle("rd_drain");
        checkOutput("rd_stb_cycles", 32'(last_stb_len), 32'd4);
        cfg_waits = 0;

        // Backpressure: five commands fit, the sixth is refused
        $display("[TB] backpressure");
        rsp_rdy_dir = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bp_cmds[i].we  = 1'($urandom_range(0, 1));
            bp_cmds[i].sel = 4'($urandom_range(1, 15));
            bp_cmds[i].adr = randAdr();
            bp_cmds[i].dat = $urandom;
        end
        acc = 0;
        cmd_valid_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            cmd_we_i  = bp_cmds[acc].we;
            cmd_sel_i = bp_cmds[acc].sel;
            cmd_adr_i = bp_cmds[acc].adr;
            cmd_dat_i = bp_cmds[acc].dat;
            @(negedge wb_clk_i);
            if (cmd_ready_o) begin
                recordCmd(bp_cmds[acc].we, bp_cmds[acc].sel, bp_cmds[acc].adr,
                          bp_cmds[acc].dat, 1'b0);
                acc++;
            end
            @(posedge wb_clk_i); #2;
            if (acc > 5) break;
        end
        checkOutput("bp_accepted", 32'(acc), 32'd5);
        checkOutput("bp_ready_low", 32'(cmd_ready_o), 32'd0);
        checkOutput("bp_rsp_pending", 32'(rsp_valid_o), 32'd1);
        cmd_valid_i = 1'b0;
        rsp_rdy_dir = 1'b1;
        waitIdle("bp_drain");

        // Ordering: write then read the same word
        $display("[TB] ordering");
        applyStimulus(1'b1, 4'hF, 32'h3000_0004, 32'h4000_0000, 1'b0);
        applyStimulus(1'b0, 4'hF, 32'h3000_0004, 32'd0, 1'b0);
        waitIdle("ord_drain");

        // Randomized traffic with random wait states and backpressure
        $display("[TB] random traffic");
        rand_mode = 1'b1;
        rand_rsp  = 1'b1;
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          randAdr(), $urandom, 1'b0);
        end
        waitIdle("rand_drain");
        rand_mode = 1'b0;
        rand_rsp  = 1'b0;

`ifdef NN_WBM_TIMEOUT_EN
        // Timeout: slave never acks, cycle aborted after 16 bus cycles
        $display("[TB] timeout");
        ack_disable = 1'b1;
        applyStimulus(1'b0, 4'hF, 32'h3000_0008, 32'd0, 1'b1);
        cyc_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge wb_clk_i); #1;
            if (wbm_cyc_o) cyc_cnt++;
            else if (cyc_cnt > 0) break;
        end
        checkOutput("to_cyc_cycles", 32'(cyc_cnt), 32'd16);
        #1;
        ack_disable = 1'b0;
        waitIdle("to_drain");
        applyStimulus(1'b0, 4'hF, 32'h3000_0008, 32'd0, 1'b0);
        waitIdle("to_next_drain");
`endif

        // Reset while a cycle is in progress with commands queued
        $display("[TB] reset mid-cycle");
        cfg_waits   = 20;
        rsp_rdy_dir = 1'b0;
        applyStimulus(1'b0, 4'hF, 32'h3000_000C, 32'd0, 1'b0);
        applyStimulus(1'b0, 4'hF, 32'h3000_0010, 32'd0, 1'b0);
        applyStimulus(1'b0, 4'hF, 32'h3000_0014, 32'd0, 1'b0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (wbm_stb_o) begin
                seen = 1;
                break;
            end
            @(posedge wb_clk_i); #1;
        end
        checkOutput("rst_mid_stb_seen", 32'(seen), 32'd1);
        #1;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        checkOutput("rst_mid_cyc", 32'(wbm_cyc_o), 32'd0);
        checkOutput("rst_mid_stb", 32'(wbm_stb_o), 32'd0);
        checkOutput("rst_mid_rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("rst_mid_cmd_ready", 32'(cmd_ready_o), 32'd1);
        checkOutput("rst_mid_busy", 32'(busy_o), 32'd0);
        exp_rsp.delete();
        exp_bus.delete();
        #1;
        wb_rst_i    = 1'b0;
        cfg_waits   = 0;
        rsp_rdy_dir = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge wb_clk_i); #1;
            if (wbm_cyc_o || wbm_stb_o || rsp_valid_o) seen++;
        end
        checkOutput("post_rst_quiet", 32'(seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

    // Global time limit
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
